// File: rtl/cpu_pkg.sv
// Shared types and instruction-field constants for the multi-cycle control unit.
package cpu_pkg;

    localparam int unsigned OPC_MSB = 9;
    localparam int unsigned RX_LSB  = 3;
    localparam int unsigned RY_LSB  = 0;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [3:0] {
        OP_MVI = 4'b0000,
        OP_MV  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_AND = 4'b0100,
        OP_INV = 4'b0101
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_T1,
        S_T2,
        S_T3
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_INV = 2'b11
    } alu_op_t;

    function automatic alu_op_t alu_sel(input opcode_t op);
        alu_op_t sel;
        case (op)
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_INV:  sel = ALU_INV;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/control_unit_reg_decoder.sv
// Register index to one-hot select; output is all zero when not enabled.
module reg_decoder
    import cpu_pkg::*;
#(
    parameter int unsigned NREG = 8
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREG-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch, decode IR, then step T1..T3 driving datapath enables.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned N    = 10,
    parameter int unsigned NREG = 8
) (
    input  logic            CLKb,
    input  logic            Reset,
    input  logic            Run,
    input  logic [N-1:0]    IR,
    output logic            IR_E,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            DinOut,
    output logic [1:0]      ALUop,
    output logic            Done
);

    state_t           state;
    state_t           state_next;
    opcode_t          opc;
    alu_op_t          alu;
    logic [IDX_W-1:0] rx_idx;
    logic [IDX_W-1:0] ry_idx;
    logic             rx_in;
    logic             rx_out;
    logic             ry_out;
    logic [NREG-1:0]  rx_hot;
    logic [NREG-1:0]  ry_hot;

    assign opc    = opcode_t'(IR[OPC_MSB -: OPC_W]);
    assign rx_idx = IR[RX_LSB +: IDX_W];
    assign ry_idx = IR[RY_LSB +: IDX_W];

    reg_decoder #(.NREG(NREG)) u_rx_dec (
        .idx    (rx_idx),
        .en     (rx_in | rx_out),
        .onehot (rx_hot)
    );

    reg_decoder #(.NREG(NREG)) u_ry_dec (
        .idx    (ry_idx),
        .en     (ry_out),
        .onehot (ry_hot)
    );

    // Rx is never both read and written in the same microcycle, so one decoder serves both.
    assign Rin   = rx_in  ? rx_hot : '0;
    assign Rout  = (rx_out ? rx_hot : '0) | ry_hot;
    assign ALUop = alu;

    always_ff @(negedge CLKb) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        IR_E       = 1'b0;
        rx_in      = 1'b0;
        rx_out     = 1'b0;
        ry_out     = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        DinOut     = 1'b0;
        alu        = ALU_ADD;
        Done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (Run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                IR_E       = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                case (opc)
                    OP_MVI: begin
                        DinOut = 1'b1;
                        rx_in  = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_MV: begin
                        ry_out = 1'b1;
                        rx_in  = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_INV: begin
                        rx_out     = 1'b1;
                        Ain        = 1'b1;
                        state_next = S_T2;
                    end
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            S_T2: begin
                Gin        = 1'b1;
                alu        = alu_sel(opc);
                ry_out     = (opc != OP_INV);
                state_next = S_T3;
            end
            S_T3: begin
                Gout  = 1'b1;
                rx_in = 1'b1;
                Done  = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Final microcycle of any instruction chains straight into the next fetch.
        if (Done) begin
            state_next = Run ? S_FETCH : S_IDLE;
        end
    end

endmodule
